// File: rtl/handshake_fifo_buffer.sv
// ---------------------------------------------------------------------------
// handshake_fifo_buffer
//   Non-transparent FIFO on an elastic valid/ready channel, NUM_SLOTS deep.
//   It decouples an upstream producer from downstream back-pressure. All
//   outputs are functions of registered state only. There is no combinational
//   path from ins/ins_valid to outs/outs_valid, and none from outs_ready to
//   ins_ready. Once a token is buffered, it sustains one token per cycle.
//
// Ports
//   clk         in   clock, rising-edge active
//   rst         in   asynchronous active-low reset
//   ins         in   input token payload, sampled only on push
//   ins_valid   in   input token present
//   ins_ready   out  buffer has a free slot this cycle
//   outs        out  head-of-FIFO payload
//   outs_valid  out  buffer holds at least one token
//   outs_ready  in   consumer takes the head token this cycle
// ---------------------------------------------------------------------------
module handshake_fifo_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

  logic [PTR_W-1:0]      head_reg, head_next;
  logic [PTR_W-1:0]      tail_reg, tail_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic [DATA_WIDTH-1:0] slot_data [NUM_SLOTS];
  logic                  push;
  logic                  pop;

  // Handshake flags come from the registered count only. This keeps
  // ins_ready independent of outs_ready.
  assign ins_ready  = (count_reg != FULL_CNT);
  assign outs_valid = (count_reg != '0);
  assign push       = ins_valid & ins_ready;
  assign pop        = outs_valid & outs_ready;

  // The pointer wraps explicitly, so depths that are not a power of two work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    head_next  = pop  ? ptr_inc(head_reg) : head_reg;
    tail_next  = push ? ptr_inc(tail_reg) : tail_reg;
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Each slot is its own register. This lets reset clear every entry, so
  // outs reads 0 after reset.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    logic [DATA_WIDTH-1:0] data_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_reg <= '0;
      end else if (push && (tail_reg == PTR_W'(gi))) begin
        data_reg <= ins;
      end
    end

    assign slot_data[gi] = data_reg;
  end

  // The head-select mux only decodes legal pointer values. For depths that
  // are not a power of two, unused codes read as 0.
  always_comb begin
    outs = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (head_reg == PTR_W'(i)) outs = slot_data[i];
    end
  end

endmodule
